// File: rtl/mem_dump.sv
// Memory read-back engine: walks a word-address range with single reads on the
// request/ack bus and streams each word to a valid/ready host port.
// Optional per-read ack timeout is enabled by defining MEM_DUMP_TIMEOUT_EN.
module mem_dump #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] count,
    output logic [15:0] mem_addr,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_busy,
    input  logic        mem_ack,
    output logic [15:0] out_data,
    output logic [15:0] out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        active,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        FIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] addr;
    logic [15:0] remaining;
    logic        timeout_hit;

    assign mem_addr   = addr;
    assign mem_wr_req = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control outputs are decoded from the state so a reset clears them at once.
    always_comb begin
        state_nxt  = state;
        mem_rd_req = 1'b0;
        active     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (count == 16'd0) ? FIN : REQ;
                end
            end
            REQ: begin
                active = 1'b1;
                if (!mem_busy) begin
                    mem_rd_req = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                active = 1'b1;
                if (mem_ack) begin
                    state_nxt = OUT;
                end else if (timeout_hit) begin
                    state_nxt = FIN;
                end
            end
            OUT: begin
                active = 1'b1;
                if (out_ready) begin
                    state_nxt = (remaining == 16'd1) ? FIN : REQ;
                end
            end
            FIN: begin
                active    = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= count;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        out_data  <= mem_rd_data;
                        out_addr  <= addr;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        addr      <= addr + 16'd1;
                        remaining <= remaining - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_DUMP_TIMEOUT_EN
    logic [31:0] wait_cnt;

    // wait_cnt is 0 in the first WAIT cycle, so the abort lands on the
    // TIMEOUT_CYCLES-th cycle spent waiting without an ack.
    assign timeout_hit = (state == WAIT) && !mem_ack &&
                         ((wait_cnt + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            error    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                error <= 1'b0;
            end else if (timeout_hit) begin
                error <= 1'b1;
            end
            if (state == WAIT && !mem_ack) begin
                wait_cnt <= wait_cnt + 32'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump: a latency-programmable memory responder, an
// expected-word queue built from the address/count rules, and per-cycle checks.
module tb_mem_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] count = '0;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [15:0] mem_rd_data = '0;
    logic        mem_busy = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] out_data;
    logic [15:0] out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        active;
    logic        done;
    logic        error;

    mem_dump #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .mem_addr   (mem_addr),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_rd_data(mem_rd_data),
        .mem_busy   (mem_busy),
        .mem_ack    (mem_ack),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .active     (active),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic [15:0] mem [0:65535];
    logic [31:0] exp_q[$];

    int   lat = 3;
    bit   no_ack = 1'b0;
    int   pend = 0;
    logic [15:0] pend_addr = '0;

    int   req_cnt, hs_cnt, done_cnt;
    int   first_req_cyc, last_req_cyc, done_cyc, first_act_cyc;
    bit   valid_seen;
    bit   exp_error = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        req_cnt = 0; hs_cnt = 0; done_cnt = 0;
        first_req_cyc = -1; last_req_cyc = -1; done_cyc = -1; first_act_cyc = -1;
        valid_seen = 1'b0;
        exp_q.delete();
    endtask

    // Expected stream: word i comes from address (sa + i) mod 2^16.
    task automatic expect_words(input logic [15:0] sa, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = sa + 16'(i);
            exp_q.push_back({a, mem[a]});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge; start is sampled at the next edge (edge 0).
    task automatic kick(input logic [15:0] sa, input logic [15:0] n, output int t0);
        start = 1'b1; start_addr = sa; count = n;
        t0 = int'(cyc);
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step(1);
            k++;
        end
        if (done_cnt == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: done never pulsed within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin
            step(1);
            k++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: out_valid never rose within %0d cycles", name, budget);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder: ack arrives lat cycles after the request cycle.
    initial forever begin
        logic        rreq;
        logic [15:0] raddr;
        @(negedge clk);
        rreq  = mem_rd_req;
        raddr = mem_addr;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (rreq && !no_ack) begin
            pend      = lat;
            pend_addr = raddr;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_ack     = 1'b1;
                mem_rd_data = mem[pend_addr];
            end
        end
    end

    // Compare process: protocol rules and the expected-word queue.
    initial begin
        bit          hold_prev;
        logic [15:0] hold_data, hold_addr;
        logic [31:0] e;
        hold_prev = 1'b0;
        hold_data = '0;
        hold_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (active && first_act_cyc < 0) first_act_cyc = int'(cyc);
                if (out_valid) valid_seen = 1'b1;
                if (mem_rd_req) begin
                    req_cnt++;
                    last_req_cyc = int'(cyc);
                    if (first_req_cyc < 0) first_req_cyc = int'(cyc);
                    chk("req_while_busy", 32'(mem_busy), 32'd0);
                    chk("req_while_valid", 32'(out_valid), 32'd0);
                    chk("wr_req_tied", 32'(mem_wr_req), 32'd0);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = int'(cyc);
                    chk("error_at_done", 32'(error), 32'(exp_error));
                end
                if (hold_prev) begin
                    chk("valid_held", 32'(out_valid), 32'd1);
                    chk("data_held", 32'(out_data), 32'(hold_data));
                    chk("addr_held", 32'(out_addr), 32'(hold_addr));
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, expected none", out_addr, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_addr", 32'(out_addr), 32'(e[31:16]));
                        chk("word_data", 32'(out_data), 32'(e[15:0]));
                    end
                end
                hold_prev = out_valid && !out_ready;
                hold_data = out_data;
                hold_addr = out_addr;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c0;
        mem[16'h0010] = 16'hA001; mem[16'h0011] = 16'hA002;
        mem[16'h0012] = 16'hA003; mem[16'h0013] = 16'hA004;
        mem[16'hFFFE] = 16'hB001; mem[16'hFFFF] = 16'hB002; mem[16'h0000] = 16'hB003;
        mem[16'h0020] = 16'hC001; mem[16'h0021] = 16'hC002; mem[16'h0022] = 16'hC003;
        mem[16'h0030] = 16'hD001; mem[16'h0031] = 16'hD002;
        mem[16'h0040] = 16'h4040; mem[16'h0050] = 16'hE001;
        clear_stats();

        step(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        step(2);

        // Four words at latency 3: period L+2 = 5, done one cycle after last handshake.
        lat = 3;
        clear_stats();
        expect_words(16'h0010, 4);
        kick(16'h0010, 16'd4, t0);
        wait_done("basic_done", 60);
        chk("basic_first_req", 32'(first_req_cyc), 32'(t0 + 1));
        chk("basic_first_active", 32'(first_act_cyc), 32'(t0 + 1));
        chk("basic_done_cycle", 32'(done_cyc), 32'(t0 + 21));
        chk("basic_req_count", 32'(req_cnt), 32'd4);
        chk("basic_hs_count", 32'(hs_cnt), 32'd4);
        chk("basic_last_data", 32'(out_data), 32'h0000_A004);
        chk("basic_last_addr", 32'(out_addr), 32'h0000_0013);
        chk("basic_active_after", 32'(active), 32'd0);
        step(2);

        // Zero-length dump.
        clear_stats();
        kick(16'h1234, 16'd0, t0);
        wait_done("zero_done", 10);
        chk("zero_done_cycle", 32'(done_cyc), 32'(t0 + 1));
        chk("zero_req_count", 32'(req_cnt), 32'd0);
        chk("zero_valid_seen", 32'(valid_seen), 32'd0);
        step(2);

        // Address wrap at latency 1.
        lat = 1;
        clear_stats();
        expect_words(16'hFFFE, 3);
        kick(16'hFFFE, 16'd3, t0);
        wait_done("wrap_done", 40);
        chk("wrap_done_cycle", 32'(done_cyc), 32'(t0 + 10));
        chk("wrap_last_addr", 32'(out_addr), 32'h0000_0000);
        chk("wrap_last_data", 32'(out_data), 32'h0000_B003);
        chk("wrap_hs_count", 32'(hs_cnt), 32'd3);
        step(2);

        // Host stall on word 2, then responder busy before word 3.
        lat = 2;
        clear_stats();
        expect_words(16'h0020, 3);
        kick(16'h0020, 16'd3, t0);
        begin
            int k = 0;
            while (hs_cnt < 1 && k < 20) begin
                step(1);
                k++;
            end
        end
        chk("stall_first_hs", 32'(hs_cnt), 32'd1);
        out_ready = 1'b0;
        step(1);
        wait_valid("stall_valid", 20);
        step(10);
        chk("stall_req_count", 32'(req_cnt), 32'd2);
        chk("stall_hs_count", 32'(hs_cnt), 32'd1);
        out_ready = 1'b1;
        mem_busy = 1'b1;
        c0 = int'(cyc);
        step(5);
        mem_busy = 1'b0;
        wait_done("stall_done", 40);
        chk("busy_req_cycle", 32'(last_req_cyc), 32'(c0 + 5));
        chk("stall_req_total", 32'(req_cnt), 32'd3);
        chk("stall_hs_total", 32'(hs_cnt), 32'd3);
        step(2);

        // Second start mid-dump must be ignored.
        lat = 3;
        clear_stats();
        expect_words(16'h0030, 2);
        kick(16'h0030, 16'd2, t0);
        start = 1'b1; start_addr = 16'h0040; count = 16'd5;
        step(1);
        start = 1'b0;
        wait_done("restart_done", 40);
        chk("restart_done_cycle", 32'(done_cyc), 32'(t0 + 11));
        chk("restart_req_count", 32'(req_cnt), 32'd2);
        chk("restart_hs_count", 32'(hs_cnt), 32'd2);
        step(2);

        // Reset while in WAIT; the responder's ack then lands after reset.
        clear_stats();
        kick(16'h0050, 16'd4, t0);
        step(1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(mem_rd_req), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_addr", 32'(out_addr), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_error", 32'(error), 32'd0);
        step(1);
        rst = 1'b0;
        clear_stats();
        step(6);
        chk("stray_ack_valid", 32'(valid_seen), 32'd0);
        chk("stray_ack_active", 32'(active), 32'd0);
        chk("stray_ack_req", 32'(req_cnt), 32'd0);
        chk("stray_ack_done", 32'(done_cnt), 32'd0);
        chk("stray_ack_data", 32'(out_data), 32'd0);
        expect_words(16'h0010, 1);
        kick(16'h0010, 16'd1, t0);
        wait_done("post_rst_done", 20);
        chk("post_rst_hs", 32'(hs_cnt), 32'd1);
        chk("post_rst_done_cycle", 32'(done_cyc), 32'(t0 + 6));
        step(2);

`ifdef MEM_DUMP_TIMEOUT_EN
        // No ack ever: abort TIMEOUT_CYCLES+1 cycles after the request.
        no_ack = 1'b1;
        exp_error = 1'b1;
        clear_stats();
        kick(16'h0060, 16'd3, t0);
        wait_done("timeout_done", 40);
        chk("timeout_done_cycle", 32'(done_cyc), 32'(t0 + 10));
        chk("timeout_req_count", 32'(req_cnt), 32'd1);
        chk("timeout_valid_seen", 32'(valid_seen), 32'd0);
        chk("timeout_error_sticky", 32'(error), 32'd1);
        step(3);
        chk("timeout_error_held", 32'(error), 32'd1);
        no_ack = 1'b0;
        exp_error = 1'b0;
        clear_stats();
        kick(16'h0000, 16'd0, t0);
        chk("timeout_error_cleared", 32'(error), 32'd0);
        wait_done("timeout_clear_done", 10);
`else
        chk("error_tied_low", 32'(error), 32'd0);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
